// File: rtl/xor_pkg.sv
// Shared encodings for the XOR frame checksum block.
// State and mode constants used by the top and the bench.
package xor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

endpackage

// File: rtl/xor_word.sv
// Word-wide XOR gate, reused as the fold element.
// Purely combinational.
module xor_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_frame_checksum.sv
// Folds a valid/ready word stream into one XOR/XNOR checksum
// per frame, with parity, saturating word count and overflow.
module xor_frame_checksum
  import xor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [LEN_W-1:0] out_count,
  output logic             out_overflow
);

  localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_LEN);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] fold;
  logic [LEN_W-1:0] cnt;
  logic             ovf;
  logic             mode_q;
  logic             accept;
  logic [WIDTH-1:0] sum;

  xor_word #(
    .WIDTH(WIDTH)
  ) u_fold (
    .a(acc),
    .b(in_data),
    .y(fold)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept)
          state_nx = in_last ? S_HOLD : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last)
          state_nx = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath keeps its last result after HOLD until the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      mode_q <= MODE_XOR;
    end else if (accept) begin
      if (state == S_IDLE) begin
        acc    <= in_data;
        cnt    <= LEN_W'(1);
        ovf    <= (MAX_LEN == 0);
        mode_q <= mode;
      end else begin
        acc <= fold;
        if (cnt < CNT_MAX) cnt <= cnt + LEN_W'(1);
        else               ovf <= 1'b1;
      end
    end
  end

  assign sum          = (mode_q == MODE_XNOR) ? ~acc : acc;
  assign out_sum      = sum;
  assign out_parity   = ^sum;
  assign out_count    = cnt;
  assign out_overflow = ovf;

endmodule
